// File: rtl/mips_main_ctrl_if.sv
// mips_main_ctrl_if: bundle between the multicycle main control FSM and the
// datapath / memory.
//   master modport: the controller (samples opcode/memReady, drives controls)
//   slave modport : the datapath side (drives opcode/memReady, takes controls)
// Signals:
//   opcode     - instruction[31:26] from the instruction register
//   memReady   - memory finished the current read/write this cycle
//   pcWrite, branchEq, branchNe, pcSrc        - PC update controls
//   iOrD, memRead, memWrite, irWrite           - memory / IR controls
//   regDst, memToReg, regWrite                 - register file write controls
//   aluSrcA, aluSrcB, aluOp                    - ALU operand / operation controls
//   illegalOp, memTimeout                      - one-cycle event pulses
//   state                                      - current FSM state code (debug)
interface mips_main_ctrl_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic [1:0] pcSrc;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       illegalOp;
    logic       memTimeout;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, branchEq, branchNe, pcSrc, iOrD, memRead, memWrite, irWrite,
               regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, illegalOp,
               memTimeout, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, branchEq, branchNe, pcSrc, iOrD, memRead, memWrite, irWrite,
               regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, illegalOp,
               memTimeout, state
    );
endinterface

// File: rtl/mips_main_ctrl.sv
// mips_main_ctrl: multicycle MIPS main control FSM.
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - synchronous active-high reset; forces every output to 0 while high
//   bus - mips_main_ctrl_if.master: opcode/memReady in, datapath controls out
// Parameter:
//   WAIT_LIMIT - cycles a memory state may wait for memReady before aborting
//                to FETCH with a memTimeout pulse; 0 waits forever (1..255).
module mips_main_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input logic              clk,
    input logic              rst,
    mips_main_ctrl_if.master bus
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] EXECUTEI = 4'd8;
    localparam logic [3:0] IMMWB    = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam bit         TIMEOUT_EN = (WAIT_LIMIT != 0);
    // Only meaningful when TIMEOUT_EN; wraps harmlessly for WAIT_LIMIT == 0.
    localparam logic [7:0] LIMIT_M1   = 8'(WAIT_LIMIT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_wait;
    logic       timeout;

    // A memory-facing state that is still waiting on memReady this cycle.
    assign mem_wait = (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE)
                      && !bus.memReady;
    // memReady on the limit cycle clears mem_wait, so a normal transition wins.
    assign timeout  = TIMEOUT_EN && mem_wait && (cnt_q == LIMIT_M1);

    always_comb begin
        state_d        = state_q;
        bus.pcWrite    = 1'b0;
        bus.branchEq   = 1'b0;
        bus.branchNe   = 1'b0;
        bus.pcSrc      = 2'b00;
        bus.iOrD       = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.irWrite    = 1'b0;
        bus.regDst     = 1'b0;
        bus.memToReg   = 1'b0;
        bus.regWrite   = 1'b0;
        bus.aluSrcA    = 1'b0;
        bus.aluSrcB    = 2'b00;
        bus.aluOp      = 3'b000;
        bus.illegalOp  = 1'b0;
        bus.memTimeout = 1'b0;
        bus.state      = 4'd0;

        if (!rst) begin
            bus.state = state_q;
            case (state_q)
                FETCH: begin
                    bus.memRead = 1'b1;
                    bus.aluSrcB = 2'b01;
                    if (bus.memReady) begin
                        bus.irWrite = 1'b1;
                        bus.pcWrite = 1'b1;
                        state_d     = DECODE;
                    end
                end
                DECODE: begin
                    // Precompute the branch target into ALUOut.
                    bus.aluSrcB = 2'b11;
                    case (bus.opcode)
                        6'h23, 6'h2B:                      state_d = MEMADR;
                        6'h00:                             state_d = EXECUTE;
                        6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: state_d = EXECUTEI;
                        6'h04, 6'h05:                      state_d = BRANCH;
                        6'h02:                             state_d = JUMP;
                        default: begin
                            bus.illegalOp = 1'b1;
                            state_d       = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                    state_d     = (bus.opcode == 6'h23) ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    bus.memRead = 1'b1;
                    bus.iOrD    = 1'b1;
                    if (bus.memReady) state_d = MEMWB;
                end
                MEMWB: begin
                    bus.memToReg = 1'b1;
                    bus.regWrite = 1'b1;
                    state_d      = FETCH;
                end
                MEMWRITE: begin
                    bus.memWrite = 1'b1;
                    bus.iOrD     = 1'b1;
                    if (bus.memReady) state_d = FETCH;
                end
                EXECUTE: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluOp   = 3'b010;
                    state_d     = ALUWB;
                end
                ALUWB: begin
                    bus.regDst   = 1'b1;
                    bus.regWrite = 1'b1;
                    state_d      = FETCH;
                end
                EXECUTEI: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                    bus.aluOp   = 3'b011;
                    state_d     = IMMWB;
                end
                IMMWB: begin
                    bus.regWrite = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    bus.aluSrcA  = 1'b1;
                    bus.aluOp    = 3'b001;
                    bus.pcSrc    = 2'b01;
                    bus.branchEq = (bus.opcode == 6'h04);
                    bus.branchNe = (bus.opcode == 6'h05);
                    state_d      = FETCH;
                end
                JUMP: begin
                    bus.pcSrc   = 2'b10;
                    bus.pcWrite = 1'b1;
                    state_d     = FETCH;
                end
                default: state_d = FETCH;
            endcase

            if (timeout) begin
                bus.memTimeout = 1'b1;
                state_d        = FETCH;
            end
        end
    end

    // Counter restarts on every state change and on a timeout (which may
    // re-enter FETCH from FETCH without a visible state change).
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || timeout) begin
            cnt_d = 8'd0;
        end else if (mem_wait) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Table-driven bench for mips_main_ctrl (WAIT_LIMIT = 4). Each cycle's
// expected outputs are pushed to a scoreboard when inputs are driven and
// popped and compared on the following falling edge.
module tb_mips_main_ctrl;

    typedef struct packed {
        logic       pcWrite;
        logic       branchEq;
        logic       branchNe;
        logic [1:0] pcSrc;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       illegalOp;
        logic       memTimeout;
        logic [3:0] state;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] opcode;
        logic       memReady;
        out_t       exp;
    } vec_t;

    // Expected output words per state, written directly from the state table.
    localparam out_t O_ZERO     = '0;
    localparam out_t O_FETCH_W  = '{memRead: 1'b1, aluSrcB: 2'b01, default: '0};
    localparam out_t O_FETCH_TO = '{memRead: 1'b1, aluSrcB: 2'b01, memTimeout: 1'b1,
                                    default: '0};
    localparam out_t O_FETCH_R  = '{pcWrite: 1'b1, memRead: 1'b1, irWrite: 1'b1,
                                    aluSrcB: 2'b01, default: '0};
    localparam out_t O_DECODE   = '{aluSrcB: 2'b11, state: 4'd1, default: '0};
    localparam out_t O_DEC_ILL  = '{aluSrcB: 2'b11, illegalOp: 1'b1, state: 4'd1,
                                    default: '0};
    localparam out_t O_MEMADR   = '{aluSrcA: 1'b1, aluSrcB: 2'b10, state: 4'd2, default: '0};
    localparam out_t O_MEMREAD  = '{memRead: 1'b1, iOrD: 1'b1, state: 4'd3, default: '0};
    localparam out_t O_MEMWB    = '{memToReg: 1'b1, regWrite: 1'b1, state: 4'd4, default: '0};
    localparam out_t O_MEMWR    = '{memWrite: 1'b1, iOrD: 1'b1, state: 4'd5, default: '0};
    localparam out_t O_MEMWR_TO = '{memWrite: 1'b1, iOrD: 1'b1, memTimeout: 1'b1,
                                    state: 4'd5, default: '0};
    localparam out_t O_EXEC     = '{aluSrcA: 1'b1, aluOp: 3'b010, state: 4'd6, default: '0};
    localparam out_t O_ALUWB    = '{regDst: 1'b1, regWrite: 1'b1, state: 4'd7, default: '0};
    localparam out_t O_EXECI    = '{aluSrcA: 1'b1, aluSrcB: 2'b10, aluOp: 3'b011,
                                    state: 4'd8, default: '0};
    localparam out_t O_IMMWB    = '{regWrite: 1'b1, state: 4'd9, default: '0};
    localparam out_t O_BNE      = '{aluSrcA: 1'b1, aluOp: 3'b001, pcSrc: 2'b01,
                                    branchNe: 1'b1, state: 4'd10, default: '0};
    localparam out_t O_BEQ      = '{aluSrcA: 1'b1, aluOp: 3'b001, pcSrc: 2'b01,
                                    branchEq: 1'b1, state: 4'd10, default: '0};
    localparam out_t O_JUMP     = '{pcSrc: 2'b10, pcWrite: 1'b1, state: 4'd11, default: '0};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;
    out_t sb[$];
    vec_t vecs[$];

    mips_main_ctrl_if bus ();

    mips_main_ctrl #(
        .WAIT_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic out_t actual();
        out_t a;
        a.pcWrite    = bus.pcWrite;
        a.branchEq   = bus.branchEq;
        a.branchNe   = bus.branchNe;
        a.pcSrc      = bus.pcSrc;
        a.iOrD       = bus.iOrD;
        a.memRead    = bus.memRead;
        a.memWrite   = bus.memWrite;
        a.irWrite    = bus.irWrite;
        a.regDst     = bus.regDst;
        a.memToReg   = bus.memToReg;
        a.regWrite   = bus.regWrite;
        a.aluSrcA    = bus.aluSrcA;
        a.aluSrcB    = bus.aluSrcB;
        a.aluOp      = bus.aluOp;
        a.illegalOp  = bus.illegalOp;
        a.memTimeout = bus.memTimeout;
        a.state      = bus.state;
        return a;
    endfunction

    function automatic void v(logic r, logic [5:0] op, logic rdy, out_t e);
        vec_t t;
        t.rst      = r;
        t.opcode   = op;
        t.memReady = rdy;
        t.exp      = e;
        vecs.push_back(t);
    endfunction

    // Drive one cycle's inputs, push its expectation, compare on the falling edge.
    task automatic step(input string name, input logic r, input logic [5:0] op,
                        input logic rdy, input out_t e);
        out_t a, x;
        rst          = r;
        bus.opcode   = op;
        bus.memReady = rdy;
        sb.push_back(e);
        @(negedge clk);
        a = actual();
        x = sb.pop_front();
        n_checks++;
        if (a !== x) begin
            n_fails++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     name, a, a.state, x, x.state);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        v(1, 6'h00, 1, O_ZERO);    v(1, 6'h00, 1, O_ZERO);
        // R-type: 4 cycles
        v(0, 6'h00, 1, O_FETCH_R); v(0, 6'h00, 1, O_DECODE);
        v(0, 6'h00, 1, O_EXEC);    v(0, 6'h00, 1, O_ALUWB);
        // lw with 3 stall cycles in MEMREAD: 8 cycles
        v(0, 6'h23, 1, O_FETCH_R); v(0, 6'h23, 1, O_DECODE); v(0, 6'h23, 1, O_MEMADR);
        v(0, 6'h23, 0, O_MEMREAD); v(0, 6'h23, 0, O_MEMREAD); v(0, 6'h23, 0, O_MEMREAD);
        v(0, 6'h23, 1, O_MEMREAD); v(0, 6'h23, 1, O_MEMWB);
        // ori, bne, beq, j
        v(0, 6'h0D, 1, O_FETCH_R); v(0, 6'h0D, 1, O_DECODE);
        v(0, 6'h0D, 1, O_EXECI);   v(0, 6'h0D, 1, O_IMMWB);
        v(0, 6'h05, 1, O_FETCH_R); v(0, 6'h05, 1, O_DECODE); v(0, 6'h05, 1, O_BNE);
        v(0, 6'h04, 1, O_FETCH_R); v(0, 6'h04, 1, O_DECODE); v(0, 6'h04, 1, O_BEQ);
        v(0, 6'h02, 1, O_FETCH_R); v(0, 6'h02, 1, O_DECODE); v(0, 6'h02, 1, O_JUMP);
        // slti (0x0A) takes the I-type path as well
        v(0, 6'h0A, 1, O_FETCH_R); v(0, 6'h0A, 1, O_DECODE);
        v(0, 6'h0A, 1, O_EXECI);   v(0, 6'h0A, 1, O_IMMWB);
        // Illegal opcode: single pulse in DECODE, back to FETCH
        v(0, 6'h3F, 1, O_FETCH_R); v(0, 6'h3F, 1, O_DEC_ILL);
        // sw stuck: timeout on the 4th MEMWRITE cycle
        v(0, 6'h2B, 1, O_FETCH_R); v(0, 6'h2B, 1, O_DECODE); v(0, 6'h2B, 1, O_MEMADR);
        v(0, 6'h2B, 0, O_MEMWR);   v(0, 6'h2B, 0, O_MEMWR);  v(0, 6'h2B, 0, O_MEMWR);
        v(0, 6'h2B, 0, O_MEMWR_TO);
        // FETCH stall with memReady on the limit cycle: no timeout
        v(0, 6'h2B, 0, O_FETCH_W); v(0, 6'h2B, 0, O_FETCH_W); v(0, 6'h2B, 0, O_FETCH_W);
        v(0, 6'h2B, 1, O_FETCH_R);
        // sw completing on the 4th MEMWRITE cycle: no timeout
        v(0, 6'h2B, 1, O_DECODE);  v(0, 6'h2B, 1, O_MEMADR);
        v(0, 6'h2B, 0, O_MEMWR);   v(0, 6'h2B, 0, O_MEMWR);  v(0, 6'h2B, 0, O_MEMWR);
        v(0, 6'h2B, 1, O_MEMWR);
        // FETCH stuck: timeout re-enters FETCH, counter restarts
        v(0, 6'h00, 0, O_FETCH_W); v(0, 6'h00, 0, O_FETCH_W); v(0, 6'h00, 0, O_FETCH_W);
        v(0, 6'h00, 0, O_FETCH_TO);
        v(0, 6'h00, 0, O_FETCH_W); v(0, 6'h00, 0, O_FETCH_W); v(0, 6'h00, 0, O_FETCH_W);
        v(0, 6'h00, 0, O_FETCH_TO);
        v(0, 6'h00, 1, O_FETCH_R); v(0, 6'h00, 1, O_DECODE);
        v(0, 6'h00, 1, O_EXEC);    v(0, 6'h00, 1, O_ALUWB);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].opcode, vecs[i].memReady,
                 vecs[i].exp);
        end

        // Reset during MEMWRITE abandons the store; FETCH resumes afterwards.
        step("rw_fetch",  0, 6'h2B, 1, O_FETCH_R);
        step("rw_decode", 0, 6'h2B, 1, O_DECODE);
        step("rw_memadr", 0, 6'h2B, 1, O_MEMADR);
        step("rw_memwr",  0, 6'h2B, 0, O_MEMWR);
        step("rw_rst",    1, 6'h2B, 0, O_ZERO);
        step("rw_after0", 0, 6'h2B, 0, O_FETCH_W);
        step("rw_after1", 0, 6'h2B, 1, O_FETCH_R);
        step("rw_after2", 0, 6'h00, 1, O_DECODE);
        step("rw_after3", 0, 6'h00, 1, O_EXEC);
        step("rw_after4", 0, 6'h00, 1, O_ALUWB);

        // Reset during a FETCH stall must clear the wait counter: after it,
        // a full 4 stalled cycles are needed before the timeout.
        step("rc_w0",  0, 6'h00, 0, O_FETCH_W);
        step("rc_w1",  0, 6'h00, 0, O_FETCH_W);
        step("rc_rst", 1, 6'h00, 0, O_ZERO);
        step("rc_a0",  0, 6'h00, 0, O_FETCH_W);
        step("rc_a1",  0, 6'h00, 0, O_FETCH_W);
        step("rc_a2",  0, 6'h00, 0, O_FETCH_W);
        step("rc_a3",  0, 6'h00, 0, O_FETCH_TO);
        step("rc_a4",  0, 6'h00, 1, O_FETCH_R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
- Multicycle MIPS main control FSM that drives the datapath and produces the 3-bit aluOp consumed by the ALU control decoder.
- aluOp encoding: 000 = add, 001 = sub, 010 = R-type (decode funct), 011 = I-type (decode opcode).
- Sits between the instruction register (opcode) and datapath muxes/enables.
- Stalls on a memory ready handshake and aborts stuck memory accesses after a configurable timeout.

Parameters:
WAIT_LIMIT, 16, max cycles a memory state waits for memReady before abort; 0 = wait forever (1..255 legal).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  instruction[31:26] from instruction register
memReady  input  1  memory has completed the current read/write this cycle
pcWrite  output  1  unconditional PC load
branchEq  output  1  PC load if ALU zero (beq)
branchNe  output  1  PC load if ALU not zero (bne)
pcSrc  output  2  00 ALU result, 01 ALUOut register, 10 jump target
iOrD  output  1  0 = memory address from PC, 1 = ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register load
regDst  output  1  0 = rt, 1 = rd
memToReg  output  1  0 = ALUOut, 1 = memory data register
regWrite  output  1  register file write
aluSrcA  output  1  0 = PC, 1 = regA
aluSrcB  output  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
aluOp  output  3  to ALU control: 000 add, 001 sub, 010 funct, 011 opcode
illegalOp  output  1  one-cycle pulse: unsupported opcode decoded
memTimeout  output  1  one-cycle pulse: memory wait exceeded WAIT_LIMIT
state  output  4  current state code (debug)

Behaviour:
- Moore outputs decoded from state, except irWrite/pcWrite in FETCH, which are gated by memReady. Every output not listed for a state is 0.
- While rst=1, all outputs are forced to 0 in the same cycle. The state register loads FETCH(0) at the edge, and the wait counter clears.
- Reset mid-access (MEMREAD/MEMWRITE) abandons the access; no write/regWrite is issued afterwards.
- State codes and behaviour:
  - FETCH(0): memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=000, pcSrc=00. If memReady: irWrite=1, pcWrite=1, next DECODE; else hold.
  - DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=000. Next by opcode:
    - 0x23/0x2B -> MEMADR
    - 0x00 -> EXECUTE
    - 0x08/0x0C/0x0D/0x0E/0x0A -> EXECUTEI
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - other -> FETCH with illegalOp=1 for that cycle (PC already advanced).
  - MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=000. Next MEMREAD if opcode 0x23, else MEMWRITE.
  - MEMREAD(3): memRead=1, iOrD=1. memReady -> MEMWB.
  - MEMWB(4): regDst=0, memToReg=1, regWrite=1 -> FETCH.
  - MEMWRITE(5): memWrite=1, iOrD=1. memReady -> FETCH.
  - EXECUTE(6): aluSrcA=1, aluSrcB=00, aluOp=010 -> ALUWB.
  - ALUWB(7): regDst=1, memToReg=0, regWrite=1 -> FETCH.
  - EXECUTEI(8): aluSrcA=1, aluSrcB=10, aluOp=011 -> IMMWB.
  - IMMWB(9): regDst=0, memToReg=0, regWrite=1 -> FETCH.
  - BRANCH(10): aluSrcA=1, aluSrcB=00, aluOp=001, pcSrc=01; branchEq=1 if opcode 0x04, branchNe=1 if 0x05 -> FETCH.
  - JUMP(11): pcSrc=10, pcWrite=1 -> FETCH.
  - Codes 12-15 -> FETCH next cycle, all outputs 0.
- opcode is sampled combinationally in DECODE, MEMADR, and BRANCH; it is stable because irWrite=0 there.
- Wait counter (8-bit):
  - Increments each cycle spent in FETCH, MEMREAD, or MEMWRITE with memReady=0.
  - Clears on any state change.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT-1 with memReady=0, the next edge goes to FETCH, clears the counter, and memTimeout=1 for the cycle it is detected.
  - memReady on the same cycle as the limit wins (normal transition, no timeout).
- Instruction latencies with memReady tied 1:
  - R-type, I-type ALU, and sw: 4 cycles
  - lw: 5 cycles
  - beq/bne and j: 3 cycles

Test Plan:
- Reset then R-type (opcode 0x00), memReady=1 -> states 0,1,6,7,0. aluOp=000, 000, 010, then regWrite=1 with regDst=1 in state 7.
- lw (0x23) with memReady low 3 cycles in MEMREAD -> holds state 3 for 4 cycles, memRead=1, iOrD=1, then MEMWB with memToReg=1, regWrite=1. Total 8 cycles.
- ori (0x0D), then bne (0x05) -> EXECUTEI aluOp=011, aluSrcB=10; BRANCH aluOp=001, branchNe=1, branchEq=0, pcSrc=01.
- Opcode 0x3F -> illegalOp pulses exactly 1 cycle in DECODE; next state FETCH; no regWrite/memWrite asserted.
- WAIT_LIMIT=4, sw with memReady held 0 -> 4 cycles in MEMWRITE, memTimeout=1 on 4th, then FETCH. Memory-ready on the 4th cycle instead -> no timeout.
- rst asserted while in MEMWRITE -> memWrite=0 same cycle, state=0 after edge, counter 0, FETCH resumes after rst falls.
